// File: rtl/lut_frac_chain.sv
// lut_frac_chain
//   Fracturable K-input LUT whose truth table is loaded through a word-wide
//   serial configuration chain. The table can be read as one K-input LUT or
//   as two (K-1)-input LUTs that share addr[K-2:0] (fractured mode). Words
//   leaving the bottom of the table are presented on config_out so several
//   LUTs can be daisy-chained inside a CLB.
//
//   Optional feature macro: LUT_FRAC_REG_OUT_EN
//     defined   -> out/out_hi registered on cclk (1-cycle lookup latency)
//     undefined -> out/out_hi combinational (zero latency)
//
// Ports
//   cclk        in   clock for config shifting and optional output register
//   rst         in   asynchronous, active-high reset
//   addr        in   LUT address [INPUTS-1:0]
//   fracture    in   1 = two (K-1)-LUTs, 0 = one K-LUT
//   out         out  full-LUT output, or low-half output when fractured
//   out_hi      out  high-half output when fractured, else 0
//   cen         in   config shift enable
//   config_in   in   config word in [CONFIG_WIDTH-1:0]
//   config_out  out  word shifted out of the table, to next LUT config_in
//   config_done out  full table has been loaded since reset
module lut_frac_chain #(
    parameter int unsigned INPUTS       = 5,
    parameter int unsigned MEM_SIZE     = 2 ** INPUTS,
    parameter int unsigned CONFIG_WIDTH = 8
) (
    input  logic                    cclk,
    input  logic                    rst,
    input  logic [INPUTS-1:0]       addr,
    input  logic                    fracture,
    output logic                    out,
    output logic                    out_hi,
    input  logic                    cen,
    input  logic [CONFIG_WIDTH-1:0] config_in,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_done
);

    localparam int unsigned WORDS = MEM_SIZE / CONFIG_WIDTH;
    localparam int unsigned CNT_W = $clog2(WORDS + 1);

    // Elaboration-time parameter sanity checks
    if (INPUTS < 2) begin : g_bad_inputs
        $error("lut_frac_chain: INPUTS must be >= 2");
    end
    if (MEM_SIZE != 2 ** INPUTS) begin : g_bad_mem_size
        $error("lut_frac_chain: MEM_SIZE must equal 2**INPUTS");
    end
    if ((MEM_SIZE % CONFIG_WIDTH) != 0) begin : g_bad_cfg_width
        $error("lut_frac_chain: MEM_SIZE must be a multiple of CONFIG_WIDTH");
    end

    logic [MEM_SIZE-1:0]     mem_q, mem_d;
    logic [CONFIG_WIDTH-1:0] config_out_q, config_out_d;
    logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
    logic                    config_done_q, config_done_d;

    // Table contents after one shift: new word enters at the top
    logic [MEM_SIZE-1:0] mem_shift_c;
    if (WORDS == 1) begin : g_single_word
        assign mem_shift_c = config_in;
    end else begin : g_multi_word
        assign mem_shift_c = {config_in, mem_q[MEM_SIZE-1:CONFIG_WIDTH]};
    end

    // Config chain next-state; count saturates so done survives pass-through shifting
    always_comb begin
        mem_d         = mem_q;
        config_out_d  = config_out_q;
        word_cnt_d    = word_cnt_q;
        config_done_d = config_done_q;
        if (cen) begin
            mem_d        = mem_shift_c;
            config_out_d = mem_q[CONFIG_WIDTH-1:0];
            if (word_cnt_q != CNT_W'(WORDS)) begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
            end
        end
        if (word_cnt_d == CNT_W'(WORDS)) begin
            config_done_d = 1'b1;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            mem_q         <= '0;
            config_out_q  <= '0;
            word_cnt_q    <= '0;
            config_done_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            config_out_q  <= config_out_d;
            word_cnt_q    <= word_cnt_d;
            config_done_q <= config_done_d;
        end
    end

    assign config_out  = config_out_q;
    assign config_done = config_done_q;

    // Lookup: fractured halves share the low address bits, top bit selects half
    logic [INPUTS-1:0] lo_idx_c, hi_idx_c;
    logic              full_c, lo_c, hi_c;
    logic              out_c, out_hi_c;

    always_comb begin
        lo_idx_c = {1'b0, addr[INPUTS-2:0]};
        hi_idx_c = {1'b1, addr[INPUTS-2:0]};
        full_c   = mem_q[addr];
        lo_c     = mem_q[lo_idx_c];
        hi_c     = mem_q[hi_idx_c];
        // Outputs held low until the whole table is present
        out_c    = config_done_q & (fracture ? lo_c : full_c);
        out_hi_c = config_done_q & fracture & hi_c;
    end

`ifdef LUT_FRAC_REG_OUT_EN
    logic out_q, out_d;
    logic out_hi_q, out_hi_d;

    always_comb begin
        out_d    = out_c;
        out_hi_d = out_hi_c;
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            out_q    <= 1'b0;
            out_hi_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
        end
    end

    assign out    = out_q;
    assign out_hi = out_hi_q;
`else
    assign out    = out_c;
    assign out_hi = out_hi_c;
`endif

endmodule

// File: tb/tb_lut_frac_chain.sv
// Directed testbench for lut_frac_chain: two instances chained through
// config_out -> config_in, INPUTS=4, CONFIG_WIDTH=8 (two words per table).
// Works for both builds; LUT_FRAC_REG_OUT_EN adds one cclk of output latency.
module tb_lut_frac_chain;

    localparam int unsigned INPUTS = 4;
    localparam int unsigned CW     = 8;

    logic          cclk;
    logic          rst;
    logic [3:0]    addr;
    logic          fracture;
    logic          cen;
    logic [CW-1:0] config_in;

    logic          up_out, up_out_hi, up_done;
    logic [CW-1:0] up_config_out;
    logic          dn_out, dn_out_hi, dn_done;
    logic [CW-1:0] dn_config_out;

    int n_checks = 0;
    int n_errors = 0;

    lut_frac_chain #(.INPUTS(INPUTS), .CONFIG_WIDTH(CW)) u_up (
        .cclk(cclk), .rst(rst), .addr(addr), .fracture(fracture),
        .out(up_out), .out_hi(up_out_hi), .cen(cen), .config_in(config_in),
        .config_out(up_config_out), .config_done(up_done)
    );

    lut_frac_chain #(.INPUTS(INPUTS), .CONFIG_WIDTH(CW)) u_dn (
        .cclk(cclk), .rst(rst), .addr(addr), .fracture(fracture),
        .out(dn_out), .out_hi(dn_out_hi), .cen(cen), .config_in(up_config_out),
        .config_out(dn_config_out), .config_done(dn_done)
    );

    always #5 cclk = ~cclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Let outputs reflect the current addr/fracture/mem
    task automatic settle();
`ifdef LUT_FRAC_REG_OUT_EN
        @(posedge cclk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic shift(input logic [CW-1:0] w);
        config_in = w;
        cen       = 1'b1;
        @(posedge cclk);
        #1;
        cen       = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // Read both tables back by sweeping addr in full mode
    task automatic read_tables(output logic [15:0] tu, output logic [15:0] td);
        fracture = 1'b0;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            settle();
            tu[a] = up_out;
            td[a] = dn_out;
        end
    endtask

    logic [15:0] t_up, t_dn;

    initial begin
        cclk      = 1'b0;
        rst       = 1'b1;
        cen       = 1'b0;
        config_in = '0;
        addr      = 4'd0;
        fracture  = 1'b0;
        #2;
        // Reset state
        check("rst_out",        32'(up_out), 0);
        check("rst_out_hi",     32'(up_out_hi), 0);
        check("rst_done",       32'(up_done), 0);
        check("rst_config_out", 32'(up_config_out), 0);
        rst = 1'b0;
        @(posedge cclk);
        #1;

        // Load 0xF0AA (first word ends in the low byte)
        shift(8'hAA);
        check("t1_done_after_w0", 32'(up_done), 0);
        shift(8'hF0);
        check("t1_done_after_w1", 32'(up_done), 1);
        fracture = 1'b0;
        addr = 4'd0;  settle(); check("t1_addr0",  32'(up_out), 0);
        addr = 4'd1;  settle(); check("t1_addr1",  32'(up_out), 1);
        addr = 4'd12; settle(); check("t1_addr12", 32'(up_out), 1);
        check("t1_out_hi_full_mode", 32'(up_out_hi), 0);
        read_tables(t_up, t_dn);
        check("t1_table", 32'(t_up), 32'hF0AA);

        // Fractured: lo = bit{0,a[2:0]}, hi = bit{1,a[2:0]}
        fracture = 1'b1;
        addr = 4'b0101; settle();
        check("t2_0101_lo", 32'(up_out), 1);
        check("t2_0101_hi", 32'(up_out_hi), 1);
        addr = 4'b1001; settle();
        check("t2_1001_lo", 32'(up_out), 1);
        check("t2_1001_hi", 32'(up_out_hi), 0);

        // Gap in cen mid-load keeps outputs gated
        pulse_rst();
        shift(8'hAA);
        for (int i = 0; i < 5; i++) begin
            fracture = i[0];
            addr     = 4'd9;  // bit 9 of 0xAA00 is 1, so gating is observable
            @(posedge cclk);
            #1;
            check("t3_gap_done",   32'(up_done), 0);
            check("t3_gap_out",    32'(up_out), 0);
            check("t3_gap_out_hi", 32'(up_out_hi), 0);
        end
        shift(8'hF0);
        check("t3_done", 32'(up_done), 1);
        read_tables(t_up, t_dn);
        check("t3_table", 32'(t_up), 32'hF0AA);

        // Chain: config_out is registered, so downstream lags one word
        pulse_rst();
        shift(8'h11);
        shift(8'h22);
        shift(8'h33);
        shift(8'h44);
        check("t4_up_done", 32'(up_done), 1);
        check("t4_dn_done", 32'(dn_done), 1);
        read_tables(t_up, t_dn);
        check("t4_up_table_4w", 32'(t_up), 32'h4433);
        check("t4_dn_table_4w", 32'(t_dn), 32'h1100);
        shift(8'h55);
        check("t4_up_config_out", 32'(up_config_out), 32'h33);
        read_tables(t_up, t_dn);
        check("t4_up_table_5w", 32'(t_up), 32'h5544);
        check("t4_dn_table_5w", 32'(t_dn), 32'h2211);

        // Reset mid-load clears immediately, reload restarts at word 0
        shift(8'h0F);  // up mem = 0x0F55, config_out = 0x44
        fracture = 1'b0;
        addr = 4'd0; settle();
        check("t5_pre_out",        32'(up_out), 1);
        check("t5_pre_config_out", 32'(up_config_out), 32'h44);
        rst = 1'b1;
        #1;
        check("t5_rst_out",        32'(up_out), 0);
        check("t5_rst_done",       32'(up_done), 0);
        check("t5_rst_config_out", 32'(up_config_out), 0);
        rst = 1'b0;
        shift(8'h0F);
        check("t5_done_after_w0", 32'(up_done), 0);
        shift(8'h00);
        check("t5_done_after_w1", 32'(up_done), 1);
        read_tables(t_up, t_dn);
        check("t5_table", 32'(t_up), 32'h000F);

        // Output latency on addr change, and async clear of the output
        pulse_rst();
        shift(8'hAA);
        shift(8'hF0);
        fracture = 1'b0;
        addr = 4'd0; settle();
        check("t6_addr0", 32'(up_out), 0);
        addr = 4'd1;
        #1;
`ifdef LUT_FRAC_REG_OUT_EN
        check("t6_addr1_before_edge", 32'(up_out), 0);
        @(posedge cclk);
        #1;
        check("t6_addr1_after_edge", 32'(up_out), 1);
`else
        check("t6_addr1_comb", 32'(up_out), 1);
`endif
        rst = 1'b1;
        #1;
        check("t6_rst_out", 32'(up_out), 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
